mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing one single-ported memory between the instruction-fetch port and the data (load/store) port of the pipelined rv32i core. It serialises accesses with a request/acknowledge handshake, gives the data port priority so older instructions drain first, and returns per-port acknowledges that the hazard logic turns into IF or MEM stalls. A compile-time starvation guard bounds how long fetch can be locked out.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `STARVE_LIMIT`, 4, fetch-wait cycles before fetch is promoted. Used only with the guard compiled in. Must be ≥1.

- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request, held until `if_ack`.
- `if_addr` input ADDR_W: fetch address, stable while `if_req`.
- `if_rdata` output DATA_W: fetched word, valid only in the `if_ack` cycle.
- `if_ack` output 1: one-cycle completion pulse for fetch.
- `d_req` input 1: data request, held until `d_ack`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: store data.
- `d_rdata` output DATA_W: load data, valid only in the `d_ack` cycle.
- `d_ack` output 1: one-cycle completion pulse for data.
- `m_req` output 1: memory request, registered.
- `m_we` output 1: memory write enable, registered.
- `m_addr` output ADDR_W: memory address, registered.
- `m_wdata` output DATA_W: memory write data, registered.
- `m_rdata` input DATA_W: memory read data, valid when `m_ack`.
- `m_ack` input 1: memory completion pulse.
- `busy` output 1: high while a memory transaction is outstanding.

## Operation
- States: IDLE, GNT_I, GNT_D.
- IDLE, arbitration:
  - `d_req` alone → GNT_D.
  - `if_req` alone → GNT_I.
  - Both requesting → GNT_D, except when the starvation guard promotes fetch (see Configuration).
  - Neither requesting → stay in IDLE.
- On the grant edge, capture the winner's address and, for data only, `d_we`/`d_wdata` into the `m_*` registers, and set `m_req`=1. For fetch, `m_we`=0.
- GNT_x: hold all `m_*` outputs stable until `m_ack`. In the `m_ack` cycle:
  - `x_ack`=1 and `x_rdata`=`m_rdata`, combinationally.
  - Next edge: `m_req`←0 and state→IDLE.
- `x_rdata` always mirrors `m_rdata`; it is meaningful only while `x_ack` is high. For stores, `d_rdata` is don't-care.
- `m_ack` is ignored in IDLE. Neither ack ever asserts in IDLE.
- The requester side treats the ack cycle as the completion of its current request. A new request is sampled only from the next IDLE cycle.
- A requester dropping `req` before its ack is a protocol violation. The arbiter still completes the memory transaction and emits the ack pulse.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, starve counter 0. Consequently `if_ack`=`d_ack`=`busy`=0.
- Reset mid-transaction: the next edge forces IDLE and drops `m_req`. A late `m_ack` is ignored. The memory must tolerate an abandoned request.
- Latency:
  - Request seen in IDLE at cycle N → `m_req` high at N+1.
  - Ack at the first `m_ack` cycle, N+1 at the earliest.
  - Back to IDLE the cycle after the ack, so there is a minimum one-cycle gap between consecutive transactions.
- Peak throughput: one access per 2 cycles with a zero-wait memory.
- Simultaneous `reset` and `m_ack`: reset wins and no ack is emitted.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments, saturating at STARVE_LIMIT, on every cycle where `if_req`=1 and state ≠ GNT_I.
  - It clears on the fetch grant edge.
  - In IDLE with both requesting and counter = STARVE_LIMIT, fetch wins.
- Not defined: no counter; data strictly wins every tie.

## Test plan
- Lone fetch, memory acks 1 cycle after `m_req`, `if_addr`=0x10, `m_rdata`=0xDEADBEEF:
  - `m_req`/`m_addr`=0x10 at N+1.
  - `if_ack` with `if_rdata`=0xDEADBEEF at N+1.
  - `busy` low at N+2.
- Lone store, `d_addr`=0x8, `d_wdata`=0x55, memory delays ack 3 cycles:
  - `m_we`=1, `m_addr`=0x8, `m_wdata`=0x55 held for all 3 cycles.
  - Single `d_ack` pulse; `if_ack` never asserts.
- Both request together, guard off:
  - Data is served first, then fetch, with exactly one IDLE cycle between transactions.
- Guard on, STARVE_LIMIT=4, `d_req` continuously high, `if_req` high:
  - Fetch is granted no later than its third arbitration, after its wait counter reaches 4.
  - Counter returns to 0 after the grant.
- Reset asserted in GNT_D, with `m_ack` pulsing in the reset cycle:
  - No `d_ack`.
  - Next cycle: `m_req`=0, state IDLE, all `m_*` outputs 0.
- `m_ack` pulse while IDLE with no requests:
  - No ack outputs; state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the data port, data first.
// Define MEM_ARB_STARVE_GUARD_EN to compile in the bounded-wait promotion of fetch.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state, state_nxt;
  logic   promote;
  logic   grant_i, grant_d;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counts every cycle fetch is left waiting, including cycles spent behind a data access.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (if_req && state != GNT_I && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign promote = (starve_cnt == CNT_MAX);
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && (!d_req || promote)) state_nxt = GNT_I;
        else if (d_req)                    state_nxt = GNT_D;
      end
      GNT_I: begin
        if_ack = m_ack && !reset;
        if (m_ack) state_nxt = IDLE;
      end
      GNT_D: begin
        d_ack = m_ack && !reset;
        if (m_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_i  = (state == IDLE) && (state_nxt == GNT_I);
  assign grant_d  = (state == IDLE) && (state_nxt == GNT_D);
  assign busy     = (state != IDLE);
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side registers are loaded only on a grant edge and otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (grant_i) begin
      m_req  <= 1'b1;
      m_we   <= 1'b0;
      m_addr <= if_addr;
    end else if (grant_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end else if (state != IDLE && m_ack) begin
      m_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; hand sequences cover reset and tie-breaking.
// Compile with MEM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, m_req, m_we, busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic        ma;
    logic [31:0] mrd;
    logic        e_iack, e_dack, e_busy, e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic        m_care, w_care;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic ma, input logic [31:0] mrd,
    input logic e_iack, input logic e_dack, input logic e_busy, input logic e_mreq,
    input logic e_mwe, input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
    input logic m_care, input logic w_care);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.ma = ma; v.mrd = mrd;
    v.e_iack = e_iack; v.e_dack = e_dack; v.e_busy = e_busy; v.e_mreq = e_mreq;
    v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.m_care = m_care; v.w_care = w_care;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic ma, input logic [31:0] mrd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
    d_addr = da; d_wdata = dwd; m_ack = ma; m_rdata = mrd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ir ia     dr dw da     dwd    ma mrd            iack dack busy mreq mwe maddr  mwdata mc wc
    vecs[0]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  1, 1);
    vecs[1]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[2]  = mk(1, 32'h10, 0, 0, 32'h0,  32'h0,  1, 32'hDEADBEEF, 1, 0, 1, 1, 0, 32'h10, 32'h0,  1, 0);
    vecs[3]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[4]  = mk(0, 32'h0,  1, 1, 32'h8,  32'h55, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[5]  = mk(0, 32'h0,  1, 1, 32'h8,  32'h55, 0, 32'h0,        0, 0, 1, 1, 1, 32'h8,  32'h55, 1, 1);
    vecs[6]  = mk(0, 32'h0,  1, 1, 32'h8,  32'h55, 0, 32'h0,        0, 0, 1, 1, 1, 32'h8,  32'h55, 1, 1);
    vecs[7]  = mk(0, 32'h0,  1, 1, 32'h8,  32'h55, 1, 32'h1234,     0, 1, 1, 1, 1, 32'h8,  32'h55, 1, 1);
    vecs[8]  = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[9]  = mk(1, 32'h20, 1, 0, 32'h30, 32'h77, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[10] = mk(1, 32'h20, 1, 0, 32'h30, 32'h77, 1, 32'hAAAA5555, 0, 1, 1, 1, 0, 32'h30, 32'h77, 1, 1);
    vecs[11] = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[12] = mk(1, 32'h20, 0, 0, 32'h0,  32'h0,  1, 32'h0BADF00D, 1, 0, 1, 1, 0, 32'h20, 32'h0,  1, 0);
    vecs[13] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[14] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[15] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[16] = mk(0, 32'h0,  1, 0, 32'h40, 32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);
    vecs[17] = mk(0, 32'h0,  0, 0, 32'h40, 32'h0,  0, 32'h0,        0, 0, 1, 1, 0, 32'h40, 32'h0,  1, 1);
    vecs[18] = mk(0, 32'h0,  0, 0, 32'h40, 32'h0,  1, 32'h99,       0, 1, 1, 1, 0, 32'h40, 32'h0,  1, 1);
    vecs[19] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,  0, 32'h0,        0, 0, 0, 0, 0, 32'h0,  32'h0,  0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dwd, vecs[i].ma, vecs[i].mrd);
      @(negedge clk);
      check($sformatf("v%0d.if_ack", i), 32'(if_ack), 32'(vecs[i].e_iack));
      check($sformatf("v%0d.d_ack", i),  32'(d_ack),  32'(vecs[i].e_dack));
      check($sformatf("v%0d.busy", i),   32'(busy),   32'(vecs[i].e_busy));
      check($sformatf("v%0d.m_req", i),  32'(m_req),  32'(vecs[i].e_mreq));
      if (vecs[i].m_care) begin
        check($sformatf("v%0d.m_we", i),   32'(m_we), 32'(vecs[i].e_mwe));
        check($sformatf("v%0d.m_addr", i), m_addr,    vecs[i].e_maddr);
      end
      if (vecs[i].w_care) check($sformatf("v%0d.m_wdata", i), m_wdata, vecs[i].e_mwdata);
      if (vecs[i].e_iack) check($sformatf("v%0d.if_rdata", i), if_rdata, vecs[i].mrd);
      if (vecs[i].e_dack && !vecs[i].dw) check($sformatf("v%0d.d_rdata", i), d_rdata, vecs[i].mrd);
      next_cycle();
    end

    // Reset while a store is granted, with m_ack arriving in the reset cycle and again just after.
    drive(0, 0, 1, 1, 32'hC, 32'h66, 0, 0);
    @(negedge clk);
    check("rst.pre_busy", 32'(busy), 32'd0);
    next_cycle();
    reset = 1'b1;
    m_ack = 1'b1;
    m_rdata = 32'h5;
    @(negedge clk);
    check("rst.granted", 32'(m_req), 32'd1);
    check("rst.d_ack_suppressed", 32'(d_ack), 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 32'h5);
    @(negedge clk);
    check("rst.busy",    32'(busy),   32'd0);
    check("rst.m_req",   32'(m_req),  32'd0);
    check("rst.m_we",    32'(m_we),   32'd0);
    check("rst.m_addr",  m_addr,      32'd0);
    check("rst.m_wdata", m_wdata,     32'd0);
    check("rst.late_d_ack",  32'(d_ack),  32'd0);
    check("rst.late_if_ack", 32'(if_ack), 32'd0);
    next_cycle();

    // Both ports requesting continuously against a zero-wait memory.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    drive(1, 32'h60, 1, 0, 32'h50, 32'h0, 1, 32'h1111);
    for (int c = 0; c < 8; c++) begin
      logic exp_i, exp_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_i = (c == 5);
      exp_d = (c == 1) || (c == 3) || (c == 7);
`else
      exp_i = 1'b0;
      exp_d = (c % 2) == 1;
`endif
      @(negedge clk);
      check($sformatf("tie%0d.if_ack", c), 32'(if_ack), 32'(exp_i));
      check($sformatf("tie%0d.d_ack", c),  32'(d_ack),  32'(exp_d));
      if (exp_i) check($sformatf("tie%0d.m_addr", c), m_addr, 32'h60);
      if (exp_d) check($sformatf("tie%0d.m_addr", c), m_addr, 32'h50);
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (c == 4) check("tie.starve_cnt_full",  32'(dut.starve_cnt), 32'd4);
      if (c == 5) check("tie.starve_cnt_clear", 32'(dut.starve_cnt), 32'd0);
`endif
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
